// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Cleans up raw push-button inputs before they reach the clock front end.
//   Each channel has three stages:
//     - a 2-flop synchronizer
//     - a debounce filter that accepts a new level only after it has held for
//       DEBOUNCE_CYCLES consecutive clocks
//     - a hold FSM that produces press/release/long-press pulses and a step
//       pulse (press plus timed auto-repeat on channels enabled in
//       REPEAT_MASK)
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-high
//   btn_raw      in   N_BTN  asynchronous raw buttons, 1 = pressed
//   btn_level    out  N_BTN  debounced level
//   btn_press    out  N_BTN  1-cycle pulse on accepted press
//   btn_release  out  N_BTN  1-cycle pulse on accepted release
//   btn_long     out  N_BTN  1-cycle pulse when the hold reaches LONG_CYCLES
//   btn_step     out  N_BTN  press pulse OR auto-repeat pulse
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               LONG_CYCLES     = 50000000,
  parameter int               REPEAT_CYCLES   = 10000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(4'b0011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_step
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam int REP_W  = $clog2(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_REPEAT   = 2'd2
  } hold_state_e;

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;

  // Two-flop synchronizer for all channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {N_BTN{1'b0}};
      sync2_r <= {N_BTN{1'b0}};
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic [DB_W-1:0]   db_cnt_r;
    logic              stable_r;
    hold_state_e       state_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [REP_W-1:0]  rep_cnt_r;
    logic              press_r;
    logic              release_r;
    logic              long_r;
    logic              step_r;

    logic              accept_s;
    logic              rise_s;
    logic              fall_s;
    logic [DB_W-1:0]   db_next_s;
    logic [HOLD_W-1:0] hold_next_s;
    logic [REP_W-1:0]  rep_next_s;

    // Acceptance decode: the synchronized level has differed from the stable
    // level for the full debounce window, so this edge flips stable.
    always_comb begin
      db_next_s   = db_cnt_r + DB_W'(1);
      hold_next_s = hold_cnt_r + HOLD_W'(1);
      rep_next_s  = rep_cnt_r + REP_W'(1);
      if ((sync2_r[g] != stable_r) && (db_cnt_r == DB_LAST)) begin
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
      rise_s = accept_s & sync2_r[g];
      fall_s = accept_s & ~sync2_r[g];
    end

    // Debounce filter: any return to the stable value restarts the window.
    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt_r <= {DB_W{1'b0}};
        stable_r <= 1'b0;
      end else if (sync2_r[g] == stable_r) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        stable_r <= sync2_r[g];
        db_cnt_r <= {DB_W{1'b0}};
      end else begin
        db_cnt_r <= db_next_s;
      end
    end

    // Hold FSM with registered pulse outputs. A release overrides whatever
    // the FSM would otherwise do in that cycle, so no step/long can coincide
    // with it.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r    <= ST_RELEASED;
        hold_cnt_r <= {HOLD_W{1'b0}};
        rep_cnt_r  <= {REP_W{1'b0}};
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        long_r     <= 1'b0;
        step_r     <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        step_r    <= 1'b0;
        if (fall_s) begin
          state_r    <= ST_RELEASED;
          hold_cnt_r <= {HOLD_W{1'b0}};
          rep_cnt_r  <= {REP_W{1'b0}};
          release_r  <= 1'b1;
        end else begin
          case (state_r)
            ST_RELEASED: begin
              if (rise_s) begin
                state_r    <= ST_HELD;
                hold_cnt_r <= {HOLD_W{1'b0}};
                rep_cnt_r  <= {REP_W{1'b0}};
                press_r    <= 1'b1;
                step_r     <= 1'b1;
              end
            end
            ST_HELD: begin
              // The long pulse is issued on the edge that brings hold_cnt to
              // its terminal value. Once there the counter parks, which is
              // what keeps non-repeat channels to a single long pulse.
              if (hold_cnt_r != HOLD_LAST) begin
                hold_cnt_r <= hold_next_s;
                if (hold_next_s == HOLD_LAST) begin
                  long_r <= 1'b1;
                  if (REPEAT_MASK[g]) begin
                    state_r   <= ST_REPEAT;
                    rep_cnt_r <= {REP_W{1'b0}};
                    step_r    <= 1'b1;
                  end
                end
              end
            end
            ST_REPEAT: begin
              if (rep_cnt_r == REP_LAST) begin
                rep_cnt_r <= {REP_W{1'b0}};
                step_r    <= 1'b1;
              end else begin
                rep_cnt_r <= rep_next_s;
              end
            end
            default: begin
              state_r    <= ST_RELEASED;
              hold_cnt_r <= {HOLD_W{1'b0}};
              rep_cnt_r  <= {REP_W{1'b0}};
            end
          endcase
        end
      end
    end

    assign btn_level[g]   = stable_r;
    assign btn_press[g]   = press_r;
    assign btn_release[g] = release_r;
    assign btn_long[g]    = long_r;
    assign btn_step[g]    = step_r;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Self-checking bench for button_conditioner with short timing parameters.
//   A behavioural model tracks, per channel, the two-clock input delay, the
//   length of the current disagreement run and the age of the current press;
//   pulses follow arithmetically from the age. Each scenario task compares the
//   DUT against that model every cycle and adds directed timing checks.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int         DB    = 4;
  localparam int         LG    = 8;
  localparam int         RP    = 3;
  localparam logic [3:0] RMASK = 4'b0011;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_long;
  logic [3:0] btn_step;

  int n_cmp;
  int n_fail;

  // model state
  bit         m_d1   [4];
  bit         m_d2   [4];
  bit         m_stab [4];
  int         m_run  [4];
  int         m_age  [4];
  logic [3:0] e_level, e_press, e_release, e_long, e_step;

  logic [19:0] dut_vec;
  logic [19:0] exp_vec;
  assign dut_vec = {btn_level, btn_press, btn_release, btn_long, btn_step};
  assign exp_vec = {e_level, e_press, e_release, e_long, e_step};

  button_conditioner #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG),
    .REPEAT_CYCLES  (RP),
    .REPEAT_MASK    (RMASK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .btn_step   (btn_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of the reference model, evaluated with the inputs present at
  // the rising edge. A new level is accepted after DB consecutive disagreeing
  // samples; a held button long-presses at age LG-1 and repeats every RP
  // clocks from then on when its channel allows it.
  task automatic model_update();
    bit chg;
    for (int c = 0; c < 4; c++) begin
      if (rst) begin
        m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_stab[c] = 1'b0;
        m_run[c] = 0;   m_age[c] = -1;
        e_level[c] = 1'b0; e_press[c] = 1'b0; e_release[c] = 1'b0;
        e_long[c]  = 1'b0; e_step[c]  = 1'b0;
      end else begin
        e_press[c] = 1'b0; e_release[c] = 1'b0; e_long[c] = 1'b0; e_step[c] = 1'b0;
        chg = 1'b0;
        if (m_d2[c] != m_stab[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_stab[c] = m_d2[c];
            m_run[c]  = 0;
            chg       = 1'b1;
            if (m_stab[c]) begin
              e_press[c] = 1'b1; e_step[c] = 1'b1; m_age[c] = 0;
            end else begin
              e_release[c] = 1'b1; m_age[c] = -1;
            end
          end
        end else begin
          m_run[c] = 0;
        end
        if (!chg && m_age[c] >= 0) begin
          m_age[c]++;
          if (m_age[c] == LG - 1) e_long[c] = 1'b1;
          if (RMASK[c] && m_age[c] >= LG - 1 && ((m_age[c] - (LG - 1)) % RP) == 0)
            e_step[c] = 1'b1;
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = btn_raw[c];
        e_level[c] = m_stab[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_raw = 4'b0000;
    for (int t = 0; t < 2; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== 20'h00000) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h expected %h", dut_vec, 20'h00000);
      end
    end
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_idle t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_clean_press();
    int press_at, rel_at, longs, presses;
    press_at = -1; rel_at = -1; longs = 0; presses = 0;
    btn_raw[0] = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL clean_press t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
      if (btn_press[0]) begin presses++; if (press_at < 0) press_at = t; end
      if (btn_release[0] && rel_at < 0) rel_at = t - 6;
      if (btn_long[0]) longs++;
      if (t == 6) btn_raw[0] = 1'b0;
    end
    n_cmp++;
    if (press_at !== 6 || presses !== 1) begin
      n_fail++;
      $display("FAIL clean_press_latency: got press at %0d (%0d pulses) expected 6 (1)", press_at, presses);
    end
    n_cmp++;
    if (rel_at !== 6) begin
      n_fail++;
      $display("FAIL clean_release_latency: got %0d expected 6", rel_at);
    end
    n_cmp++;
    if (longs !== 0) begin
      n_fail++;
      $display("FAIL clean_no_long: got %0d long pulses expected 0", longs);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pattern;
    int seen;
    pattern = 8'b0111_0111; // applied LSB first: 1,1,1,0,1,1,1,0
    seen = 0;
    for (int t = 0; t < 18; t++) begin
      btn_raw[2] = (t < 8) ? pattern[t] : 1'b0;
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bounce t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
      if (btn_press[2] || btn_level[2] || btn_step[2]) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL bounce_rejected: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_hold(input int ch);
    logic [20:0] step_seen, long_seen, exp_step_m, exp_long_m;
    int extra_press, found;
    step_seen = '0; long_seen = '0; extra_press = 0; found = 0;
    exp_step_m = 21'd1;
    if (RMASK[ch]) begin
      for (int a = LG - 1; a <= 20; a += RP) exp_step_m[a] = 1'b1;
    end
    exp_long_m = '0;
    exp_long_m[LG-1] = 1'b1;
    btn_raw[ch] = 1'b1;
    for (int t = 1; t <= 12 && found == 0; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL hold%0d_wait t=%0d: got %h expected %h", ch, t, dut_vec, exp_vec);
      end
      if (btn_press[ch]) found = 1;
    end
    n_cmp++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL hold%0d_press: got no press expected press within 12 clocks", ch);
    end else begin
      step_seen[0] = btn_step[ch];
      long_seen[0] = btn_long[ch];
      for (int a = 1; a <= 20; a++) begin
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL hold%0d age=%0d: got %h expected %h", ch, a, dut_vec, exp_vec);
        end
        step_seen[a] = btn_step[ch];
        long_seen[a] = btn_long[ch];
        if (btn_press[ch]) extra_press++;
      end
      n_cmp++;
      if (step_seen !== exp_step_m) begin
        n_fail++;
        $display("FAIL hold%0d_steps: got %b expected %b", ch, step_seen, exp_step_m);
      end
      n_cmp++;
      if (long_seen !== exp_long_m) begin
        n_fail++;
        $display("FAIL hold%0d_long: got %b expected %b", ch, long_seen, exp_long_m);
      end
      n_cmp++;
      if (extra_press !== 0) begin
        n_fail++;
        $display("FAIL hold%0d_single_press: got %0d extra expected 0", ch, extra_press);
      end
    end
    btn_raw[ch] = 1'b0;
    found = 0;
    for (int t = 1; t <= 12 && found == 0; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL hold%0d_release t=%0d: got %h expected %h", ch, t, dut_vec, exp_vec);
      end
      if (btn_release[ch]) found = 1;
    end
    n_cmp++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL hold%0d_release_pulse: got none expected release within 12 clocks", ch);
    end
    repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    int found;
    found = 0;
    btn_raw[1:0] = 2'b11;
    for (int t = 1; t <= 12 && found == 0; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL simul t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
      if (btn_press != 4'b0000) found = 1;
    end
    n_cmp++;
    if (btn_press !== 4'b0011 || btn_step !== 4'b0011 || btn_level !== 4'b0011) begin
      n_fail++;
      $display("FAIL simul_pulses: got press %b step %b level %b expected 0011 each",
               btn_press, btn_step, btn_level);
    end
    btn_raw[1:0] = 2'b00;
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL simul_release t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    int found, press_at, rels;
    found = 0; press_at = -1; rels = 0;
    btn_raw[1] = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rst_mid_hold t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec !== 20'h00000) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h expected %h", dut_vec, 20'h00000);
    end
    rst = 1'b0;
    for (int t = 1; t <= 12 && found == 0; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rst_mid_repress t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
      if (btn_release[1]) rels++;
      if (btn_press[1]) begin found = 1; press_at = t; end
    end
    n_cmp++;
    if (press_at !== 6 || rels !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_latency: got press at %0d with %0d releases expected 6 with 0",
               press_at, rels);
    end
    btn_raw[1] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rst_mid_release t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 40; seg++) begin
      btn_raw = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      for (int t = 0; t < len; t++) begin
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec || (btn_step & ~btn_level) !== 4'b0000) begin
          n_fail++;
          $display("FAIL random seg=%0d t=%0d: got %h expected %h", seg, t, dut_vec, exp_vec);
        end
      end
    end
    btn_raw = 4'b0000;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_drain t=%0d: got %h expected %h", t, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    btn_raw = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold(0);
    test_hold(3);
    test_simultaneous();
    test_reset_mid_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
